// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants for the fetch sequencer.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } pcseq_state_t;

  localparam logic [31:0] PC_INC     = 32'd4;
  localparam int          JUMP_IDX_W = 26;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/redirect bundle between the PC sequencer and imem/decode; the sequencer is master.
interface pc_sequencer_if;
  import mips_pkg::*;

  logic                  STALL;
  logic                  FETCH_REQ;
  logic                  FETCH_ACK;
  logic [31:0]           PC;
  logic                  BRANCH_TAKEN;
  logic [31:0]           BRANCH_IMM;
  logic                  JUMP;
  logic [JUMP_IDX_W-1:0] JUMP_INDEX;
  logic [31:0]           REDIR_PC4;
  logic                  FLUSH;

  modport master (
    input  STALL, FETCH_ACK, BRANCH_TAKEN, BRANCH_IMM, JUMP, JUMP_INDEX, REDIR_PC4,
    output FETCH_REQ, PC, FLUSH
  );

  modport slave (
    output STALL, FETCH_ACK, BRANCH_TAKEN, BRANCH_IMM, JUMP, JUMP_INDEX, REDIR_PC4,
    input  FETCH_REQ, PC, FLUSH
  );

endinterface

// File: rtl/shift_left2.sv
// Word-to-byte offset scaling: out = in << 2, purely combinational, no flow control.
module shift_left2 (
  input  logic [31:0] in,
  output logic [31:0] out
);

  assign out = in << 2;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and imem fetch sequencer: one PC+4 per accepted fetch, redirects land next cycle.
// A redirect without ack parks its target in DRAIN until the outstanding fetch returns.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         RST,
  pc_sequencer_if.master bus
);

  pcseq_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pend_pc_q;
  logic         flush_q;

  logic [31:0]  imm_x4;
  logic [31:0]  branch_tgt;
  logic [31:0]  jump_tgt;
  logic [31:0]  redir_tgt;
  logic         redirect;
  logic         accept;

  shift_left2 u_shift_left2 (
    .in  (bus.BRANCH_IMM),
    .out (imm_x4)
  );

  assign branch_tgt = bus.REDIR_PC4 + imm_x4;
  assign jump_tgt   = {bus.REDIR_PC4[31:28], bus.JUMP_INDEX, 2'b00};
  // Branch is the older instruction, so it wins when both resolve together.
  assign redir_tgt  = bus.BRANCH_TAKEN ? branch_tgt : jump_tgt;
  assign redirect   = bus.BRANCH_TAKEN | bus.JUMP;
  assign accept     = bus.FETCH_ACK & ~bus.STALL;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= 32'd0;
      flush_q   <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            if (bus.FETCH_ACK) begin
              pc_q    <= redir_tgt;
              flush_q <= 1'b1;
            end else begin
              pend_pc_q <= redir_tgt;
              state_q   <= DRAIN;
            end
          end else if (accept) begin
            pc_q <= pc_q + PC_INC;
          end
        end
        DRAIN: begin
          if (redirect) begin
            pend_pc_q <= redir_tgt;
          end
          // The old request must complete before the new target goes out; STALL cannot hold it.
          if (bus.FETCH_ACK) begin
            pc_q    <= redirect ? redir_tgt : pend_pc_q;
            flush_q <= 1'b1;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.FETCH_REQ = (state_q != IDLE);
  assign bus.PC        = pc_q;
  assign bus.FLUSH     = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected PC/FETCH_REQ/FLUSH queued at drive time, checked after each edge.
module tb_pc_sequencer;
  import mips_pkg::*;

  logic CLK;
  logic RST;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        req;
    logic        flush;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic stall, input logic bt, input logic [31:0] imm,
                       input logic jmp, input logic [25:0] jidx, input logic [31:0] rpc4);
    bus.FETCH_ACK    = ack;
    bus.STALL        = stall;
    bus.BRANCH_TAKEN = bt;
    bus.BRANCH_IMM   = imm;
    bus.JUMP         = jmp;
    bus.JUMP_INDEX   = jidx;
    bus.REDIR_PC4    = rpc4;
  endtask

  // Push the expectation for the next edge, advance one cycle, then pop and compare.
  task automatic step(input string tag, input logic [31:0] pc, input logic req, input logic flush);
    exp_t e;
    e.tag = tag; e.pc = pc; e.req = req; e.flush = flush;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check({e.tag, ".pc"},    bus.PC,                 e.pc);
    check({e.tag, ".req"},   {31'd0, bus.FETCH_REQ}, {31'd0, e.req});
    check({e.tag, ".flush"}, {31'd0, bus.FLUSH},     {31'd0, e.flush});
  endtask

  task automatic idle_in();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst.pc",    bus.PC,                 32'h0);
    check("rst.req",   {31'd0, bus.FETCH_REQ}, 32'd0);
    check("rst.flush", {31'd0, bus.FLUSH},     32'd0);

    // Release; a jump presented during IDLE must be ignored.
    RST = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 26'h5, 32'h8000_0004);
    step("idle_ign", 32'h0, 1'b1, 1'b0);
    idle_in();
    step("seq4",  32'h4,  1'b1, 1'b0);
    step("seq8",  32'h8,  1'b1, 1'b0);
    step("seq12", 32'hC,  1'b1, 1'b0);
    step("seq16", 32'h10, 1'b1, 1'b0);

    // Stall with ack held high: PC holds for three edges.
    bus.STALL = 1'b1;
    for (int i = 0; i < 3; i++) step("stall_hold", 32'h10, 1'b1, 1'b0);
    bus.STALL = 1'b0;
    step("stall_rel", 32'h14, 1'b1, 1'b0);

    // Branch and jump together: branch wins.
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 26'h100, 32'h0040_0008);
    step("br_prio", 32'h0040_0000, 1'b1, 1'b1);
    idle_in();
    step("br_after", 32'h0040_0004, 1'b1, 1'b0);

    // Back-to-back redirects each flush.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 26'h40, 32'h1000_0004);
    step("b2b_j", 32'h1000_0100, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h4, 1'b0, 26'd0, 32'h1000_0104);
    step("b2b_b", 32'h1000_0114, 1'b1, 1'b1);
    idle_in();
    step("b2b_end", 32'h1000_0118, 1'b1, 1'b0);

    // Jump without ack: drain two cycles, then land on ack.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h3FF_FFFF, 32'h8000_0004);
    step("drain0", 32'h1000_0118, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
    step("drain1", 32'h1000_0118, 1'b1, 1'b0);
    idle_in();
    step("drain_land", 32'h8FFF_FFFC, 1'b1, 1'b1);
    step("drain_next", 32'h9000_0000, 1'b1, 1'b0);

    // Wrap at the top of the address space.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 26'h3FF_FFFF, 32'hF000_0004);
    step("wrap_set", 32'hFFFF_FFFC, 1'b1, 1'b1);
    idle_in();
    step("wrap", 32'h0, 1'b1, 1'b0);
    step("wrap4", 32'h4, 1'b1, 1'b0);

    // Newer redirect in DRAIN overwrites the pending target; STALL ignored on landing.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h10, 32'h0000_0004);
    step("ovr_j", 32'h4, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 26'd0, 32'h0000_0104);
    step("ovr_b", 32'h4, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
    step("ovr_land", 32'h144, 1'b1, 1'b1);

    // Same-cycle redirect on the ack edge in DRAIN takes precedence over pend_pc.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h1000, 32'h0000_0200);
    step("dsame_j", 32'h144, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h1, 1'b0, 26'd0, 32'h0000_0304);
    step("dsame_land", 32'h308, 1'b1, 1'b1);
    idle_in();
    step("dsame_next", 32'h30C, 1'b1, 1'b0);

    // Async reset in DRAIN drops the pending target.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h5, 32'h8000_0004);
    step("rdrain", 32'h30C, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
    #2;
    RST = 1'b1;
    #1;
    check("arst.pc",    bus.PC,                 32'h0);
    check("arst.req",   {31'd0, bus.FETCH_REQ}, 32'd0);
    check("arst.flush", {31'd0, bus.FLUSH},     32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle_in();
    step("arst_idle", 32'h0, 1'b1, 1'b0);
    step("arst_seq",  32'h4, 1'b1, 1'b0);
    step("arst_seq2", 32'h8, 1'b1, 1'b0);

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
